// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C sensor sequencer: FSM state
// encoding and the sensor initialisation write table.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT_REQ  = 3'd1,
    ST_INIT_WAIT = 3'd2,
    ST_ARMED     = 3'd3,
    ST_RD_REQ    = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_PUBLISH   = 3'd6,
    ST_FAULT     = 3'd7
  } seq_state_e;

  // One register write issued during sensor bring-up.
  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] wdata;
  } init_entry_t;

  localparam int INIT_LEN = 4;

  // Wake the device, set the filter, then the gyro and accel ranges.
  localparam init_entry_t INIT_TABLE [INIT_LEN] = '{
    '{reg_addr: 8'h6B, wdata: 8'h00},
    '{reg_addr: 8'h1A, wdata: 8'h03},
    '{reg_addr: 8'h1B, wdata: 8'h08},
    '{reg_addr: 8'h1C, wdata: 8'h08}
  };

endpackage

// File: rtl/i2c_sensor_sequencer_poll_timer.sv
// Free-running poll divider: one-cycle tick every POLL_DIV cycles while run
// is high; the count is held at zero whenever run is low.
module poll_timer #(
  parameter int POLL_DIV = 10000
) (
  input  logic clk_system,
  input  logic reset_n,
  input  logic run,
  output logic tick
);

  localparam logic [19:0] CNT_LAST = 20'(POLL_DIV - 1);

  logic [19:0] cnt_q;
  logic [19:0] cnt_d;

  // Next count: clear when stopped, wrap at the end of the period.
  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk_system or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/i2c_sensor_sequencer.sv
// Sensor sequencer: initialises an I2C sensor with a fixed write table,
// then periodically reads a burst of registers and publishes them.
//
// Master handshake: m_req is a valid that holds with stable m_rw/m_dev/
// m_reg/m_wdata until the master pulses m_ack (the ready); the command is
// transferred in that cycle and m_req drops. The master later pulses m_done
// (with m_nack) once per accepted command. m_ack/m_done are only honoured
// in the REQ/WAIT state that expects them.
module i2c_sensor_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h68,
  parameter int         POLL_DIV  = 10000,
  parameter logic [7:0] START_REG = 8'h3B,
  parameter int         BURST_LEN = 6,
  parameter int         MAX_RETRY = 3
) (
  input  logic                   clk_system,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   fault_clr,
  output logic                   m_req,
  output logic                   m_rw,
  output logic [6:0]             m_dev,
  output logic [7:0]             m_reg,
  output logic [7:0]             m_wdata,
  input  logic                   m_ack,
  input  logic                   m_done,
  input  logic                   m_nack,
  input  logic [7:0]             m_rdata,
  output logic [8*BURST_LEN-1:0] sample,
  output logic                   sample_valid,
  output logic                   init_done,
  output logic                   fault,
  output logic [7:0]             overrun_cnt,
  output logic [2:0]             dbg_state
);

  localparam logic [1:0] INIT_LAST  = 2'(INIT_LEN - 1);
  localparam logic [2:0] RD_LAST    = 3'(BURST_LEN - 1);
  localparam logic [7:0] RETRY_LAST = 8'(MAX_RETRY - 1);

  seq_state_e             state_q;
  logic [1:0]             init_idx_q;
  logic [2:0]             rd_idx_q;
  logic [7:0]             retry_q;
  logic                   m_req_q;
  logic                   m_rw_q;
  logic [6:0]             m_dev_q;
  logic [7:0]             m_reg_q;
  logic [7:0]             m_wdata_q;
  logic [8*BURST_LEN-1:0] shadow_q;
  logic [8*BURST_LEN-1:0] sample_q;
  logic                   sample_valid_q;
  logic                   init_done_q;
  logic                   fault_q;
  logic [7:0]             overrun_q;
  logic                   tick;

  poll_timer #(
    .POLL_DIV (POLL_DIV)
  ) u_poll_timer (
    .clk_system (clk_system),
    .reset_n    (reset_n),
    .run        (init_done_q & en),
    .tick       (tick)
  );

  // Sequencer FSM with registered command, status and sample outputs.
  always_ff @(posedge clk_system or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      init_idx_q     <= '0;
      rd_idx_q       <= '0;
      retry_q        <= '0;
      m_req_q        <= 1'b0;
      m_rw_q         <= 1'b0;
      m_dev_q        <= '0;
      m_reg_q        <= '0;
      m_wdata_q      <= '0;
      shadow_q       <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
      fault_q        <= 1'b0;
      overrun_q      <= '0;
    end else begin
      sample_valid_q <= 1'b0;

      // Only ARMED can start a burst; any other tick is a dropped poll.
      if (tick && (state_q != ST_ARMED) && (overrun_q != 8'hFF)) begin
        overrun_q <= overrun_q + 8'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (en) begin
            retry_q <= '0;
            if (init_done_q) begin
              state_q <= ST_ARMED;
            end else begin
              init_idx_q <= '0;
              m_req_q    <= 1'b1;
              m_rw_q     <= 1'b0;
              m_dev_q    <= DEV_ADDR;
              m_reg_q    <= INIT_TABLE[0].reg_addr;
              m_wdata_q  <= INIT_TABLE[0].wdata;
              state_q    <= ST_INIT_REQ;
            end
          end
        end

        ST_INIT_REQ, ST_RD_REQ: begin
          if (m_ack) begin
            m_req_q <= 1'b0;
            state_q <= (state_q == ST_INIT_REQ) ? ST_INIT_WAIT : ST_RD_WAIT;
          end
        end

        ST_INIT_WAIT: begin
          if (m_done) begin
            if (m_nack) begin
              if (retry_q == RETRY_LAST) begin
                retry_q     <= '0;
                fault_q     <= 1'b1;
                init_done_q <= 1'b0;
                shadow_q    <= '0;
                state_q     <= ST_FAULT;
              end else begin
                retry_q <= retry_q + 8'd1;
                if (en) begin
                  m_req_q <= 1'b1;
                  state_q <= ST_INIT_REQ;
                end else begin
                  state_q <= ST_IDLE;
                end
              end
            end else begin
              retry_q <= '0;
              if (init_idx_q == INIT_LAST) begin
                init_done_q <= 1'b1;
                state_q     <= ST_ARMED;
              end else if (en) begin
                init_idx_q <= init_idx_q + 2'd1;
                m_req_q    <= 1'b1;
                m_reg_q    <= INIT_TABLE[init_idx_q + 2'd1].reg_addr;
                m_wdata_q  <= INIT_TABLE[init_idx_q + 2'd1].wdata;
                state_q    <= ST_INIT_REQ;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
        end

        ST_ARMED: begin
          if (!en) begin
            state_q <= ST_IDLE;
          end else if (tick) begin
            rd_idx_q  <= '0;
            m_req_q   <= 1'b1;
            m_rw_q    <= 1'b1;
            m_dev_q   <= DEV_ADDR;
            m_reg_q   <= START_REG;
            m_wdata_q <= '0;
            state_q   <= ST_RD_REQ;
          end
        end

        ST_RD_WAIT: begin
          if (m_done) begin
            if (m_nack) begin
              if (retry_q == RETRY_LAST) begin
                retry_q     <= '0;
                fault_q     <= 1'b1;
                init_done_q <= 1'b0;
                shadow_q    <= '0;
                state_q     <= ST_FAULT;
              end else begin
                retry_q <= retry_q + 8'd1;
                if (en) begin
                  m_req_q <= 1'b1;
                  state_q <= ST_RD_REQ;
                end else begin
                  state_q <= ST_IDLE;
                end
              end
            end else begin
              retry_q <= '0;
              // Byte 0 of the burst lands in the most significant byte.
              for (int b = 0; b < BURST_LEN; b++) begin
                if (rd_idx_q == 3'(b)) begin
                  shadow_q[(BURST_LEN-1-b)*8 +: 8] <= m_rdata;
                end
              end
              if (!en) begin
                state_q <= ST_IDLE;
              end else if (rd_idx_q == RD_LAST) begin
                state_q <= ST_PUBLISH;
              end else begin
                rd_idx_q <= rd_idx_q + 3'd1;
                m_reg_q  <= m_reg_q + 8'd1;
                m_req_q  <= 1'b1;
                state_q  <= ST_RD_REQ;
              end
            end
          end
        end

        ST_PUBLISH: begin
          sample_q       <= shadow_q;
          sample_valid_q <= 1'b1;
          state_q        <= ST_ARMED;
        end

        ST_FAULT: begin
          if (fault_clr) begin
            fault_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_req        = m_req_q;
  assign m_rw         = m_rw_q;
  assign m_dev        = m_dev_q;
  assign m_reg        = m_reg_q;
  assign m_wdata      = m_wdata_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign init_done    = init_done_q;
  assign fault        = fault_q;
  assign overrun_cnt  = overrun_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_i2c_sensor_sequencer.sv
// Directed bench for i2c_sensor_sequencer with a behavioural I2C master.
`timescale 1ns/1ps
module tb_i2c_sensor_sequencer;
  import i2c_seq_pkg::*;

  logic        clk_system;
  logic        reset_n;
  logic        en;
  logic        fault_clr;
  logic        m_req;
  logic        m_rw;
  logic [6:0]  m_dev;
  logic [7:0]  m_reg;
  logic [7:0]  m_wdata;
  logic        m_ack;
  logic        m_done;
  logic        m_nack;
  logic [7:0]  m_rdata;
  logic [47:0] sample;
  logic        sample_valid;
  logic        init_done;
  logic        fault;
  logic [7:0]  overrun_cnt;
  logic [2:0]  dbg_state;

  i2c_sensor_sequencer #(
    .POLL_DIV (100)
  ) dut (
    .clk_system   (clk_system),
    .reset_n      (reset_n),
    .en           (en),
    .fault_clr    (fault_clr),
    .m_req        (m_req),
    .m_rw         (m_rw),
    .m_dev        (m_dev),
    .m_reg        (m_reg),
    .m_wdata      (m_wdata),
    .m_ack        (m_ack),
    .m_done       (m_done),
    .m_nack       (m_nack),
    .m_rdata      (m_rdata),
    .sample       (sample),
    .sample_valid (sample_valid),
    .init_done    (init_done),
    .fault        (fault),
    .overrun_cnt  (overrun_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk_system = 1'b0;
  always #5 clk_system = ~clk_system;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int sv_cnt   = 0;

  logic [23:0] log_q[$];   // observed commands {dev, rw, reg, wdata}
  logic [23:0] exp_q[$];   // expected commands

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_system) if (sample_valid) sv_cnt++;

  // ---------------- master model ----------------
  int         mst_lat   = 2;
  int         mst_cnt   = 0;
  bit         mst_busy  = 1'b0;
  int         req_age   = 0;
  logic [7:0] cur_reg   = 8'h00;
  int         nack_left = 0;
  logic [7:0] nack_reg  = 8'h00;

  // Acks on the second cycle of m_req, finishes mst_lat cycles later;
  // read data is the register address.
  initial begin
    m_ack = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
    forever begin
      @(negedge clk_system);
      m_ack = 1'b0; m_done = 1'b0; m_nack = 1'b0;
      if (mst_busy) begin
        if (mst_cnt <= 1) begin
          mst_busy = 1'b0;
          m_done   = 1'b1;
          m_rdata  = cur_reg;
          if (nack_left > 0 && cur_reg == nack_reg) begin
            m_nack = 1'b1;
            nack_left--;
          end
        end else begin
          mst_cnt--;
        end
      end else if (m_req) begin
        req_age++;
        if (req_age >= 2) begin
          m_ack    = 1'b1;
          req_age  = 0;
          mst_busy = 1'b1;
          mst_cnt  = mst_lat;
          cur_reg  = m_reg;
          log_q.push_back({m_dev, m_rw, m_reg, m_wdata});
        end
      end else begin
        req_age = 0;
      end
    end
  end

  // ---------------- wait helpers ----------------
  function automatic bit flag_hit(input int which);
    case (which)
      0:       return init_done === 1'b1;
      1:       return fault === 1'b1;
      2:       return dbg_state === 3'(ST_RD_WAIT);
      default: return overrun_cnt === 8'hFF;
    endcase
  endfunction

  task automatic wait_flag(input string tag, input int which, input int limit);
    for (int c = 0; c < limit; c++) begin
      @(negedge clk_system);
      if (flag_hit(which)) return;
    end
    check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_sv(input string tag, input int limit, output int cycles);
    cycles = 0;
    while (cycles < limit) begin
      @(negedge clk_system);
      cycles++;
      if (sample_valid) return;
    end
    check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_init_log(input string tag);
    exp_q.delete();
    for (int i = 0; i < INIT_LEN; i++)
      exp_q.push_back({7'h68, 1'b0, INIT_TABLE[i].reg_addr, INIT_TABLE[i].wdata});
    check({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), (i < log_q.size()) ? 64'(log_q[i]) : 64'hDEAD, 64'(exp_q[i]));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         cyc;
    int         win;
    int         n3d;
    int         sv0;
    logic [7:0] r;

    reset_n = 1'b0; en = 1'b0; fault_clr = 1'b0;
    repeat (3) @(negedge clk_system);

    // Reset values
    check("rst_req", m_req, 0);
    check("rst_fields", {m_rw, m_dev, m_reg, m_wdata}, 0);
    check("rst_sample", {sample_valid, sample}, 0);
    check("rst_status", {init_done, fault}, 0);
    check("rst_ovr", overrun_cnt, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // Init sequence
    reset_n = 1'b1;
    @(negedge clk_system);
    en = 1'b1;
    wait_flag("init", 0, 500);
    check("init_done", init_done, 1);
    check("init_state", dbg_state, ST_ARMED);
    check_init_log("init");

    // First burst, rdata = register address
    log_q.delete();
    wait_sv("poll0", 300, cyc);
    check("poll_sample", sample, 48'h3B3C3D3E3F40);
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      r = 8'h3B + 8'(i);
      exp_q.push_back({7'h68, 1'b1, r, 8'h00});
    end
    check("poll_count", log_q.size(), 6);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("poll_cmd%0d", i), (i < log_q.size()) ? 64'(log_q[i]) : 64'hDEAD, 64'(exp_q[i]));

    // One publish per 100 cycles
    win = sv_cnt;
    repeat (1000) @(negedge clk_system);
    check("sv_per_1000", sv_cnt - win, 10);
    wait_sv("period", 300, cyc);
    check("sv_period", cyc, 100);
    check("ovr_fast", overrun_cnt, 0);

    // Two NACKs on 3D then success
    nack_reg = 8'h3D; nack_left = 2;
    log_q.delete();
    wait_sv("nack", 300, cyc);
    n3d = 0;
    foreach (log_q[i]) if (log_q[i][15:8] == 8'h3D) n3d++;
    check("nack_3d_reqs", n3d, 3);
    check("nack_total", log_q.size(), 8);
    check("nack_sample", sample, 48'h3B3C3D3E3F40);
    check("nack_fault", fault, 0);
    check("nack_ovr", overrun_cnt, 0);

    // Reset in the middle of RD_WAIT, late m_done afterwards
    mst_lat = 10;
    wait_flag("rdwait", 2, 300);
    #2;
    reset_n = 1'b0;
    en = 1'b0;
    #1;
    check("mid_rst_req", m_req, 0);
    check("mid_rst_fields", {m_rw, m_dev, m_reg, m_wdata}, 0);
    check("mid_rst_sample", {sample_valid, sample}, 0);
    check("mid_rst_status", {init_done, fault}, 0);
    check("mid_rst_ovr", overrun_cnt, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    repeat (2) @(negedge clk_system);
    reset_n = 1'b1;
    sv0 = sv_cnt;
    repeat (20) @(negedge clk_system);
    check("late_done_seen", mst_busy, 0);
    check("late_state", dbg_state, ST_IDLE);
    check("late_sample", sample, 0);
    check("late_no_sv", sv_cnt - sv0, 0);
    check("late_req", m_req, 0);
    mst_lat = 2;

    // Three NACKs on init write to 1B -> FAULT
    log_q.delete();
    nack_reg = 8'h1B; nack_left = 3;
    en = 1'b1;
    wait_flag("fault", 1, 500);
    check("fault_flag", fault, 1);
    check("fault_init_done", init_done, 0);
    check("fault_state", dbg_state, ST_FAULT);
    check("fault_cmds", log_q.size(), 5);
    check("fault_last_cmd", (log_q.size() == 5) ? 64'(log_q[4]) : 64'hDEAD, {7'h68, 1'b0, 8'h1B, 8'h08});
    repeat (5) @(negedge clk_system);
    check("fault_hold", dbg_state, ST_FAULT);
    check("fault_req", m_req, 0);

    // fault_clr restarts init from the first entry
    log_q.delete();
    fault_clr = 1'b1;
    @(negedge clk_system);
    fault_clr = 1'b0;
    check("clr_fault", fault, 0);
    wait_flag("reinit", 0, 500);
    check_init_log("reinit");

    // Slow master: ticks get dropped until the counter saturates
    wait_sv("pre_ovr", 300, cyc);
    check("pre_ovr", overrun_cnt, 0);
    mst_lat = 60;
    repeat (2000) @(negedge clk_system);
    check("ovr_grows", overrun_cnt != 8'd0, 1);
    wait_flag("ovr_sat", 3, 60000);
    check("ovr_sat", overrun_cnt, 255);
    repeat (500) @(negedge clk_system);
    check("ovr_hold", overrun_cnt, 255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
